// File: rtl/hazard_forward_unit_if.sv
// RF-stage hazard/forwarding bundle: RF decode fields in, forwarding/stall/flush controls out.
// Purely a wiring bundle; no latency and no backpressure of its own.
// master = pipeline RF stage, slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] rn_RF;
    logic [REG_W-1:0] rm_RF;
    logic             useA_RF;
    logic             useB_RF;
    logic             useFlags_RF;
    logic [REG_W-1:0] regWrite_RF;
    logic             regWrite_E_RF;
    logic             mem_read_RF;
    logic             setFlag_RF;
    logic             branch_taken_RF;

    logic [1:0]       fwdA_RF;
    logic [1:0]       fwdB_RF;
    logic             fwdFlags_RF;
    logic             stall;
    logic             bubble_RF;
    logic             flush_IF;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rn_RF, rm_RF, useA_RF, useB_RF, useFlags_RF,
               regWrite_RF, regWrite_E_RF, mem_read_RF, setFlag_RF, branch_taken_RF,
        input  fwdA_RF, fwdB_RF, fwdFlags_RF, stall, bubble_RF, flush_IF, stall_count
    );

    modport slave (
        input  rn_RF, rm_RF, useA_RF, useB_RF, useFlags_RF,
               regWrite_RF, regWrite_E_RF, mem_read_RF, setFlag_RF, branch_taken_RF,
        output fwdA_RF, fwdB_RF, fwdFlags_RF, stall, bubble_RF, flush_IF, stall_count
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand/flag forwarding from an EX/MEM/WB shadow of RF destination fields.
// Latency: controls are combinational in the same cycle; shadow slots advance one stage per clock.
// Backpressure: a load-use hit raises stall (hold IF/RF) and bubble (zero RF/EX) for one cycle.
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    hazard_forward_unit_if.slave hf
);
    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             we;
        logic             ld;
        logic             sf;
    } slot_t;

    localparam logic [REG_W-1:0] XZR = '1;

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d;
    logic [CNT_W-1:0] cnt_q;

    logic hit_a_ex, hit_a_mem, hit_a_wb;
    logic hit_b_ex, hit_b_mem, hit_b_wb;
    logic stall_c;

    // XZR reads as zero everywhere, so a write to it is never a real producer.
    function automatic logic hit(input slot_t s, input logic [REG_W-1:0] src, input logic use_src);
        return use_src && s.we && (s.dst == src) && (src != XZR);
    endfunction

    function automatic logic [1:0] sel(input logic h_ex, input logic h_mem, input logic h_wb);
        if (h_ex)       return 2'b01;
        else if (h_mem) return 2'b10;
        else if (h_wb)  return 2'b11;
        else            return 2'b00;
    endfunction

    assign hit_a_ex  = hit(ex_q,  hf.rn_RF, hf.useA_RF);
    assign hit_a_mem = hit(mem_q, hf.rn_RF, hf.useA_RF);
    assign hit_a_wb  = hit(wb_q,  hf.rn_RF, hf.useA_RF);
    assign hit_b_ex  = hit(ex_q,  hf.rm_RF, hf.useB_RF);
    assign hit_b_mem = hit(mem_q, hf.rm_RF, hf.useB_RF);
    assign hit_b_wb  = hit(wb_q,  hf.rm_RF, hf.useB_RF);

    // Only EX can hold a load whose data is not yet available to the consumer.
    assign stall_c = ex_q.ld & (hit_a_ex | hit_b_ex);

    assign hf.fwdA_RF     = sel(hit_a_ex, hit_a_mem, hit_a_wb);
    assign hf.fwdB_RF     = sel(hit_b_ex, hit_b_mem, hit_b_wb);
    assign hf.fwdFlags_RF = hf.useFlags_RF & ex_q.sf;
    assign hf.stall       = stall_c;
    assign hf.bubble_RF   = stall_c;
    assign hf.flush_IF    = hf.branch_taken_RF & ~stall_c;
    assign hf.stall_count = cnt_q;

    always_comb begin
        ex_d = '0;
        if (!stall_c) begin
            ex_d.dst = hf.regWrite_RF;
            ex_d.we  = hf.regWrite_E_RF;
            ex_d.ld  = hf.mem_read_RF;
            ex_d.sf  = hf.setFlag_RF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall_c && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: expected control words queued at drive time, popped at negedge.
// A second narrow-counter instance shares the stimulus to reach counter saturation quickly.
module tb_hazard_forward_unit;
    logic clk;
    logic reset;

    hazard_forward_unit_if #(.REG_W(5), .CNT_W(16)) hif ();
    hazard_forward_unit_if #(.REG_W(5), .CNT_W(4))  hif2 ();

    hazard_forward_unit #(.REG_W(5), .CNT_W(16)) dut (.clk(clk), .reset(reset), .hf(hif));
    hazard_forward_unit #(.REG_W(5), .CNT_W(4))  dut2 (.clk(clk), .reset(reset), .hf(hif2));

    assign hif2.rn_RF           = hif.rn_RF;
    assign hif2.rm_RF           = hif.rm_RF;
    assign hif2.useA_RF         = hif.useA_RF;
    assign hif2.useB_RF         = hif.useB_RF;
    assign hif2.useFlags_RF     = hif.useFlags_RF;
    assign hif2.regWrite_RF     = hif.regWrite_RF;
    assign hif2.regWrite_E_RF   = hif.regWrite_E_RF;
    assign hif2.mem_read_RF     = hif.mem_read_RF;
    assign hif2.setFlag_RF      = hif.setFlag_RF;
    assign hif2.branch_taken_RF = hif.branch_taken_RF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        ff;
        logic        st;
        logic        fl;
        logic [15:0] cnt;
        bit          chk_fwd;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = '0;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
            $error("check %s.%s did not match", tag, fld);
        end
    endtask

    task automatic drv(input logic [4:0] rn, input logic [4:0] rm, input logic ua, input logic ub,
                       input logic uf, input logic [4:0] rd, input logic we, input logic ld,
                       input logic sf, input logic bt);
        hif.rn_RF           = rn;
        hif.rm_RF           = rm;
        hif.useA_RF         = ua;
        hif.useB_RF         = ub;
        hif.useFlags_RF     = uf;
        hif.regWrite_RF     = rd;
        hif.regWrite_E_RF   = we;
        hif.mem_read_RF     = ld;
        hif.setFlag_RF      = sf;
        hif.branch_taken_RF = bt;
    endtask

    // Queue the expectation for the currently driven RF inputs, check at negedge, then advance one clock.
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic ff,
                        input logic st, input logic fl, input bit chk_fwd);
        exp_t e;
        exp_t o;
        e.tag = tag; e.fa = fa; e.fb = fb; e.ff = ff; e.st = st; e.fl = fl;
        e.cnt = exp_cnt; e.chk_fwd = chk_fwd;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        if (o.chk_fwd) begin
            chk(o.tag, "fwdA", 32'(hif.fwdA_RF), 32'(o.fa));
            chk(o.tag, "fwdB", 32'(hif.fwdB_RF), 32'(o.fb));
        end
        chk(o.tag, "fwdFlags", 32'(hif.fwdFlags_RF), 32'(o.ff));
        chk(o.tag, "stall",    32'(hif.stall),       32'(o.st));
        chk(o.tag, "bubble",   32'(hif.bubble_RF),   32'(o.st));
        chk(o.tag, "flush",    32'(hif.flush_IF),    32'(o.fl));
        chk(o.tag, "count",    32'(hif.stall_count), 32'(o.cnt));
        if (o.st && reset && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step("nop", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;

        // Forward from EX
        drv(1, 2, 1, 1, 0, 3, 1, 0, 0, 0);
        step("add_x3", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(3, 4, 1, 1, 0, 8, 1, 0, 0, 0);
        step("fwd_ex", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nops(3);

        // Priority EX > MEM > WB
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
            step("wr_x5", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drv(5, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        step("prio_ex", 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        nops(3);
        for (int k = 0; k < 2; k++) begin
            drv(0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
            step("wr_x5", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        nops(1);
        drv(5, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        step("prio_mem", 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        nops(3);
        drv(0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step("wr_x5", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nops(2);
        drv(5, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        step("prio_wb", 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step("wr_x5", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(5, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        step("use_gate", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        nops(3);

        // Load-use stall, with a taken branch held off during the stall
        drv(1, 0, 1, 0, 0, 7, 1, 1, 0, 0);
        step("ldur_x7", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(2, 7, 1, 1, 0, 9, 1, 0, 0, 1);
        step("ld_use", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ld_after", 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        nops(3);

        // XZR never forwards or stalls
        drv(0, 0, 0, 0, 0, 31, 1, 0, 0, 0);
        step("wr_xzr", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(31, 31, 1, 1, 0, 0, 0, 0, 0, 0);
        step("rd_xzr", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(0, 0, 0, 0, 0, 31, 1, 1, 0, 0);
        step("ld_xzr", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(31, 31, 1, 1, 0, 0, 0, 0, 0, 0);
        step("rd_xzr_ld", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nops(3);

        // Flag forwarding and flush
        drv(1, 2, 1, 1, 0, 10, 1, 0, 1, 0);
        step("subs", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("bcond", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("bcond_nosf", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-stream while a load-use hazard would otherwise fire
        drv(1, 0, 1, 0, 0, 7, 1, 1, 0, 0);
        step("ldur_pre", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(2, 7, 1, 1, 0, 9, 1, 0, 0, 1);
        reset   = 1'b0;
        exp_cnt = '0;
        step("mid_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        drv(2, 7, 1, 1, 0, 9, 1, 0, 0, 0);
        step("post_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nops(3);

        // Repeated load-use pairs: one stall every other cycle
        drv(0, 7, 0, 1, 0, 7, 1, 1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step("sat", (2'b00), (i == 0) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b00),
                 1'b0, (i % 2 == 1), 1'b0, (i % 2 == 0));
        end
        @(negedge clk);
        chk("sat_narrow", "count", 32'(hif2.stall_count), 32'h0000_000F);
        chk("sat_main",   "count", 32'(hif.stall_count),  32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
